// File: rtl/i2c_pkg.sv
// Shared types and constants for the I2C register target.
package i2c_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StAddr,
        StAddrAck,
        StReg,
        StRegAck,
        StTx,
        StTxAck,
        StIgnore
    } i2c_slv_state_t;

    localparam logic I2C_WR = 1'b0;
    localparam logic I2C_RD = 1'b1;

endpackage

// File: rtl/i2c_register_slave_if.sv
// Host-side register port of the I2C register target.
interface i2c_register_slave_if;

    logic [7:0]  regaddr;
    logic        rd_req;
    logic [15:0] regin;
    logic        rd_done;
    logic        busy;

    modport slave (
        output regaddr,
        output rd_req,
        output rd_done,
        output busy,
        input  regin
    );

    modport master (
        input  regaddr,
        input  rd_req,
        input  rd_done,
        input  busy,
        output regin
    );

endinterface

// File: rtl/i2c_line_filter.sv
// Two-flop synchroniser plus glitch filter for one I2C line, with edge strobes.
module i2c_line_filter #(
    parameter int unsigned FILTER_LEN = 3
) (
    input  logic clk,
    input  logic rstn,
    input  logic line,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [1:0] sync_q;
    logic [3:0] cnt_q, cnt_d;
    logic       level_q, level_d;
    logic       rise_q, rise_d;
    logic       fall_q, fall_d;

    // Idle bus level is high, so reset there to avoid a spurious edge.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sync_q  <= 2'b11;
            cnt_q   <= '0;
            level_q <= 1'b1;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            sync_q  <= {sync_q[0], line};
            cnt_q   <= cnt_d;
            level_q <= level_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
        end
    end

    always_comb begin
        cnt_d   = '0;
        level_d = level_q;
        rise_d  = 1'b0;
        fall_d  = 1'b0;
        if (sync_q[1] != level_q) begin
            if (cnt_q == 4'(FILTER_LEN - 1)) begin
                level_d = sync_q[1];
                rise_d  = sync_q[1];
                fall_d  = !sync_q[1];
            end else begin
                cnt_d = cnt_q + 4'd1;
            end
        end
    end

    assign level = level_q;
    assign rise  = rise_q;
    assign fall  = fall_q;

endmodule

// File: rtl/i2c_register_slave.sv
// I2C target serving a 16-bit read-only register window behind an 8-bit pointer.
module i2c_register_slave
    import i2c_pkg::*;
#(
    parameter logic [6:0]  SLAVE_ADDR = 7'h36,
    parameter int unsigned FILTER_LEN = 3
) (
    input  logic clk,
    input  logic rstn,
    input  logic scl,
    inout  wire  sda,
    i2c_register_slave_if.slave host
);

    logic scl_lvl, scl_rise, scl_fall;
    logic sda_lvl, sda_rise, sda_fall;
    logic start, stop;

    i2c_slv_state_t state_q, state_d;
    logic [3:0]  bit_cnt_q, bit_cnt_d;
    logic [7:0]  shift_q, shift_d;
    logic        is_read_q, is_read_d;
    logic        ack_on_q, ack_on_d;
    logic        byte_idx_q, byte_idx_d;
    logic [15:0] data_q, data_d;
    logic [7:0]  regaddr_q, regaddr_d;
    logic        sda_oe_q, sda_oe_d;
    logic        rd_req_c, rd_done_c;
    logic [7:0]  rx_byte, tx_byte;

    i2c_line_filter #(.FILTER_LEN(FILTER_LEN)) u_scl_filter (
        .clk   (clk),
        .rstn  (rstn),
        .line  (scl),
        .level (scl_lvl),
        .rise  (scl_rise),
        .fall  (scl_fall)
    );

    i2c_line_filter #(.FILTER_LEN(FILTER_LEN)) u_sda_filter (
        .clk   (clk),
        .rstn  (rstn),
        .line  (sda),
        .level (sda_lvl),
        .rise  (sda_rise),
        .fall  (sda_fall)
    );

    // An SDA edge coinciding with an SCL edge is data, never a bus condition.
    assign start = sda_fall && scl_lvl && !scl_rise && !scl_fall;
    assign stop  = sda_rise && scl_lvl && !scl_rise && !scl_fall;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q    <= StIdle;
            bit_cnt_q  <= '0;
            shift_q    <= '0;
            is_read_q  <= 1'b0;
            ack_on_q   <= 1'b0;
            byte_idx_q <= 1'b0;
            data_q     <= '0;
            regaddr_q  <= '0;
            sda_oe_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            is_read_q  <= is_read_d;
            ack_on_q   <= ack_on_d;
            byte_idx_q <= byte_idx_d;
            data_q     <= data_d;
            regaddr_q  <= regaddr_d;
            sda_oe_q   <= sda_oe_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        is_read_d  = is_read_q;
        ack_on_d   = ack_on_q;
        byte_idx_d = byte_idx_q;
        data_d     = data_q;
        regaddr_d  = regaddr_q;
        sda_oe_d   = sda_oe_q;
        rd_req_c   = 1'b0;
        rd_done_c  = 1'b0;
        rx_byte    = {shift_q[6:0], sda_lvl};
        tx_byte    = byte_idx_q ? data_q[7:0] : data_q[15:8];

        if (start) begin
            state_d   = StAddr;
            bit_cnt_d = '0;
            shift_d   = '0;
            ack_on_d  = 1'b0;
            sda_oe_d  = 1'b0;
        end else if (stop) begin
            state_d   = StIdle;
            bit_cnt_d = '0;
            ack_on_d  = 1'b0;
            sda_oe_d  = 1'b0;
        end else begin
            unique case (state_q)
                StAddr: begin
                    if (scl_rise) begin
                        shift_d   = rx_byte;
                        bit_cnt_d = bit_cnt_q + 4'd1;
                        if (bit_cnt_q == 4'd7) begin
                            bit_cnt_d = '0;
                            if (rx_byte[7:1] == SLAVE_ADDR) begin
                                state_d   = StAddrAck;
                                is_read_d = (rx_byte[0] == I2C_RD);
                                rd_req_c  = (rx_byte[0] == I2C_RD);
                            end else begin
                                state_d = StIgnore;
                            end
                        end
                    end
                end
                // ACK spans one full SCL low/high/low window between two falls.
                StAddrAck, StRegAck: begin
                    if (scl_fall) begin
                        if (!ack_on_q) begin
                            ack_on_d = 1'b1;
                            sda_oe_d = 1'b1;
                        end else begin
                            ack_on_d = 1'b0;
                            sda_oe_d = 1'b0;
                            if (state_q == StRegAck) begin
                                state_d = StIgnore;
                            end else if (is_read_q) begin
                                // First data bit goes out on the same fall that ends the ACK.
                                data_d     = host.regin;
                                byte_idx_d = 1'b0;
                                sda_oe_d   = !host.regin[15];
                                bit_cnt_d  = 4'd1;
                                state_d    = StTx;
                            end else begin
                                bit_cnt_d = '0;
                                state_d   = StReg;
                            end
                        end
                    end
                end
                StReg: begin
                    if (scl_rise) begin
                        shift_d   = rx_byte;
                        bit_cnt_d = bit_cnt_q + 4'd1;
                        if (bit_cnt_q == 4'd7) begin
                            bit_cnt_d = '0;
                            regaddr_d = rx_byte;
                            ack_on_d  = 1'b0;
                            state_d   = StRegAck;
                        end
                    end
                end
                StTx: begin
                    if (scl_fall) begin
                        if (bit_cnt_q == 4'd8) begin
                            sda_oe_d  = 1'b0;
                            bit_cnt_d = '0;
                            state_d   = StTxAck;
                        end else begin
                            sda_oe_d  = !tx_byte[3'd7 - bit_cnt_q[2:0]];
                            bit_cnt_d = bit_cnt_q + 4'd1;
                        end
                    end
                end
                StTxAck: begin
                    if (scl_rise) begin
                        if (!sda_lvl) begin
                            byte_idx_d = !byte_idx_q;
                            state_d    = StTx;
                        end else begin
                            rd_done_c = 1'b1;
                            state_d   = StIgnore;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign sda          = sda_oe_q ? 1'b0 : 1'bz;
    assign host.regaddr = regaddr_q;
    assign host.rd_req  = rd_req_c;
    assign host.rd_done = rd_done_c;
    assign host.busy    = (state_q != StIdle);

endmodule

// File: tb/tb_i2c_register_slave.sv
// Bit-banged I2C master bench with a transaction-level model of the register target.
module tb_i2c_register_slave;

    localparam logic [6:0] SLV = 7'h36;

    logic clk   = 1'b0;
    logic rstn  = 1'b0;
    logic scl   = 1'b1;
    logic m_low = 1'b0;
    wire  sda;

    assign sda = m_low ? 1'b0 : 1'bz;
    pullup (sda);

    i2c_register_slave_if host ();

    i2c_register_slave #(
        .SLAVE_ADDR (SLV),
        .FILTER_LEN (3)
    ) dut (
        .clk  (clk),
        .rstn (rstn),
        .scl  (scl),
        .sda  (sda),
        .host (host)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    int req_cnt  = 0;
    int done_cnt = 0;
    logic [7:0] model_regaddr = 8'h00;

    always @(negedge clk) begin
        if (host.rd_req === 1'b1) req_cnt <= req_cnt + 1;
        if (host.rd_done === 1'b1) done_cnt <= done_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    // One SCL period of 64 clk; SDA set mid-low, sampled mid-high.
    task automatic bit_xfer(input logic out, output logic in);
        wait_clk(16);
        m_low = !out;
        wait_clk(16);
        scl = 1'b1;
        wait_clk(16);
        in = sda;
        wait_clk(16);
        scl = 1'b0;
    endtask

    task automatic i2c_start();
        if (scl == 1'b0) begin
            wait_clk(16);
            m_low = 1'b0;
            wait_clk(16);
            scl = 1'b1;
        end
        wait_clk(16);
        m_low = 1'b1;
        wait_clk(16);
        scl = 1'b0;
    endtask

    task automatic i2c_stop();
        wait_clk(16);
        m_low = 1'b1;
        wait_clk(16);
        scl = 1'b1;
        wait_clk(16);
        m_low = 1'b0;
        wait_clk(32);
    endtask

    task automatic write_bits(input logic [7:0] b, input int nbits, output logic ack);
        logic dummy;
        for (int i = nbits - 1; i >= 0; i--) bit_xfer(b[i], dummy);
        bit_xfer(1'b1, ack);
    endtask

    task automatic read_byte(input logic nack, output logic [7:0] b);
        logic v;
        logic dummy;
        for (int i = 7; i >= 0; i--) begin
            bit_xfer(1'b1, v);
            b[i] = v;
        end
        bit_xfer(nack, dummy);
    endtask

    task automatic read_txn(input logic do_ptr, input logic [7:0] ptr, input int nbytes,
                            input logic [15:0] word);
        logic ack;
        logic [7:0] b;
        logic [15:0] latched;
        int req0;
        int done0;
        req0 = req_cnt;
        done0 = done_cnt;
        host.regin = word;
        latched = word;
        i2c_start();
        if (do_ptr) begin
            write_bits({SLV, 1'b0}, 8, ack);
            check("wr_addr_ack", 32'(ack), 32'd0);
            write_bits(ptr, 8, ack);
            check("ptr_ack", 32'(ack), 32'd0);
            model_regaddr = ptr;
            i2c_start();
        end
        write_bits({SLV, 1'b1}, 8, ack);
        check("rd_addr_ack", 32'(ack), 32'd0);
        for (int k = 0; k < nbytes; k++) begin
            read_byte(k == nbytes - 1, b);
            check("rd_byte", 32'(b), (k % 2 == 0) ? 32'(latched >> 8) : 32'(latched & 16'hFF));
            host.regin = 16'($urandom);
        end
        i2c_stop();
        check("regaddr", 32'(host.regaddr), 32'(model_regaddr));
        check("busy_after_stop", 32'(host.busy), 32'd0);
        check("rd_req_count", 32'(req_cnt - req0), 32'd1);
        check("rd_done_count", 32'(done_cnt - done0), 32'd1);
    endtask

    task automatic bad_addr_txn(input logic [6:0] a, input logic rw);
        logic ack;
        int req0;
        req0 = req_cnt;
        i2c_start();
        write_bits({a, rw}, 8, ack);
        check("bad_addr_nack", 32'(ack), 32'd1);
        write_bits(8'($urandom), 8, ack);
        check("bad_data_nack", 32'(ack), 32'd1);
        i2c_stop();
        check("bad_regaddr", 32'(host.regaddr), 32'(model_regaddr));
        check("bad_no_req", 32'(req_cnt - req0), 32'd0);
        check("bad_busy", 32'(host.busy), 32'd0);
    endtask

    // First address bit clocked by a short SCL pulse of the given width.
    task automatic glitch_txn(input int pulse, input logic expect_shift);
        logic ack;
        logic dummy;
        logic [7:0] ab;
        logic [7:0] ptr;
        ab = {SLV, 1'b0};
        ptr = 8'($urandom);
        i2c_start();
        wait_clk(16);
        m_low = !ab[7];
        wait_clk(4);
        scl = 1'b1;
        wait_clk(pulse);
        scl = 1'b0;
        if (!expect_shift) begin
            wait_clk(12);
            scl = 1'b1;
            wait_clk(32);
            scl = 1'b0;
        end
        for (int i = 6; i >= 0; i--) bit_xfer(ab[i], dummy);
        bit_xfer(1'b1, ack);
        check("glitch_addr_ack", 32'(ack), 32'd0);
        write_bits(ptr, 8, ack);
        check("glitch_ptr_ack", 32'(ack), 32'd0);
        model_regaddr = ptr;
        i2c_stop();
        check("glitch_regaddr", 32'(host.regaddr), 32'(model_regaddr));
    endtask

    initial begin
        #800000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        logic ack;
        logic dummy;
        logic [6:0] bad;
        logic [15:0] w;
        host.regin = 16'h0000;
        wait_clk(5);
        check("rst_sda", 32'(sda), 32'd1);
        check("rst_regaddr", 32'(host.regaddr), 32'd0);
        check("rst_busy", 32'(host.busy), 32'd0);
        check("rst_rd_req", 32'(host.rd_req), 32'd0);
        check("rst_rd_done", 32'(host.rd_done), 32'd0);
        rstn = 1'b1;
        wait_clk(20);

        read_txn(1'b1, 8'h0E, 2, 16'hA55A);

        bad_addr_txn(7'h37, 1'b0);
        for (int i = 0; i < 2; i++) begin
            do bad = 7'($urandom); while (bad == SLV);
            bad_addr_txn(bad, 1'($urandom));
        end

        read_txn(1'b0, 8'h00, 4, 16'h1234);

        glitch_txn(2, 1'b0);
        glitch_txn(5, 1'b1);

        // Pointer write followed by a surplus data byte.
        i2c_start();
        write_bits({SLV, 1'b0}, 8, ack);
        check("extra_addr_ack", 32'(ack), 32'd0);
        write_bits(8'h0C, 8, ack);
        check("extra_ptr_ack", 32'(ack), 32'd0);
        model_regaddr = 8'h0C;
        write_bits(8'($urandom), 8, ack);
        check("extra_byte_nack", 32'(ack), 32'd1);
        check("extra_busy_ignore", 32'(host.busy), 32'd1);
        i2c_stop();
        check("extra_regaddr", 32'(host.regaddr), 32'h0C);
        check("extra_busy_stop", 32'(host.busy), 32'd0);

        for (int i = 0; i < 5; i++) begin
            read_txn(1'($urandom), 8'($urandom), int'($urandom_range(1, 4)), 16'($urandom));
        end

        // Reset while the target drives a 0 data bit.
        w = {1'b0, 15'($urandom)};
        host.regin = w;
        i2c_start();
        write_bits({SLV, 1'b1}, 8, ack);
        check("rst_txn_addr_ack", 32'(ack), 32'd0);
        wait_clk(16);
        m_low = 1'b0;
        wait_clk(16);
        scl = 1'b1;
        wait_clk(8);
        check("tx_zero_driven", 32'(sda), 32'd0);
        @(posedge clk);
        #2;
        rstn = 1'b0;
        #1;
        check("midrst_sda", 32'(sda), 32'd1);
        check("midrst_busy", 32'(host.busy), 32'd0);
        model_regaddr = 8'h00;
        check("midrst_regaddr", 32'(host.regaddr), 32'd0);
        wait_clk(4);
        rstn = 1'b1;
        wait_clk(8);
        scl = 1'b0;
        i2c_stop();
        bit_xfer(1'b1, dummy);
        read_txn(1'b1, 8'($urandom), 2, 16'($urandom));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
